ula_arbiter: RTL and testbench

//   Shares one ALU datapath between two requesters: front-panel sequencer = port 0, auto-test sequencer = port 1.

---
 rtl/ula_arbiter.sv | 135 +++++++++++++
 tb/tb_ula_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ALU between the front-panel (port 0) and
// auto-test (port 1) sequencers, with a watchdog bounding the wait for alu_done.
module ula_arbiter #(
  parameter int W       = 3,
  parameter int RW      = 6,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [2:0]    req0_op,
  output logic          req0_ready,
  output logic          req0_rsp_valid,
  output logic [RW-1:0] req0_result,
  output logic [2:0]    req0_flags,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [2:0]    req1_op,
  output logic          req1_ready,
  output logic          req1_rsp_valid,
  output logic [RW-1:0] req1_result,
  output logic [2:0]    req1_flags,
  output logic          alu_start,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_op,
  input  logic          alu_done,
  input  logic [RW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_ovf,
  output logic          busy,
  output logic          grant_id
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic            last_grant;
  logic            sel;
  logic [WD_W-1:0] wd_cnt;
  logic [RW-1:0]   cap_result;
  logic [2:0]      cap_flags;

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (&v) ? v : v + WD_W'(1);
  endfunction

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) sel = ~last_grant;
  end

  assign req0_ready = (state == S_IDLE) && req0_valid && !sel;
  assign req1_ready = (state == S_IDLE) && req1_valid && sel;
  assign busy       = (state != S_IDLE);

  // Watchdog expiry reports a zero result with only the overflow flag set.
  always_comb begin
    cap_result = '0;
    cap_flags  = 3'b100;
    if (alu_done) begin
      cap_result = alu_result;
      cap_flags  = {alu_ovf, alu_neg, alu_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      alu_start      <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      wd_cnt         <= '0;
      req0_rsp_valid <= 1'b0;
      req0_result    <= '0;
      req0_flags     <= '0;
      req1_rsp_valid <= 1'b0;
      req1_result    <= '0;
      req1_flags     <= '0;
    end else begin
      alu_start      <= 1'b0;
      req0_rsp_valid <= 1'b0;
      req1_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            alu_a     <= sel ? req1_a  : req0_a;
            alu_b     <= sel ? req1_b  : req0_b;
            alu_op    <= sel ? req1_op : req0_op;
            grant_id  <= sel;
            alu_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done || wd_cnt == WD_LAST) begin
            if (grant_id) begin
              req1_result    <= cap_result;
              req1_flags     <= cap_flags;
              req1_rsp_valid <= 1'b1;
            end else begin
              req0_result    <= cap_result;
              req0_flags     <= cap_flags;
              req0_rsp_valid <= 1'b1;
            end
            state <= S_RESP;
          end else begin
            wd_cnt <= wd_sat_inc(wd_cnt);
          end
        end
        S_RESP: begin
          last_grant <= grant_id;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-timeline model of arbitration, latency and responses.
module tb_ula_arbiter;

  localparam int W       = 3;
  localparam int RW      = 6;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_rsp_valid;
  logic [W-1:0]  req0_a, req0_b;
  logic [2:0]    req0_op, req0_flags;
  logic [RW-1:0] req0_result;
  logic          req1_valid, req1_ready, req1_rsp_valid;
  logic [W-1:0]  req1_a, req1_b;
  logic [2:0]    req1_op, req1_flags;
  logic [RW-1:0] req1_result;
  logic          alu_start, alu_done, alu_zero, alu_neg, alu_ovf;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [RW-1:0] alu_result;
  logic          busy, grant_id;

  always #5 clk = ~clk;

  ula_arbiter #(.W(W), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready), .req0_rsp_valid(req0_rsp_valid),
    .req0_result(req0_result), .req0_flags(req0_flags),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready), .req1_rsp_valid(req1_rsp_valid),
    .req1_result(req1_result), .req1_flags(req1_flags),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
    .busy(busy), .grant_id(grant_id)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Behavioural ALU: returns {result, ovf, neg, zero}.
  function automatic logic [RW+2:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
    logic [RW-1:0] r;
    logic          ovf;
    ovf = 1'b0;
    case (op)
      3'd0: r = RW'(a) + RW'(b);
      3'd1: r = RW'(a) - RW'(b);
      3'd2: r = RW'(a & b);
      3'd3: if (b == '0) begin r = '0; ovf = 1'b1; end else r = RW'(a / b);
      3'd4: r = RW'(a | b);
      3'd5: r = RW'(a ^ b);
      3'd6: r = RW'(a) * RW'(b);
      default: r = '0;
    endcase
    return {r, ovf, r[RW-1], (r == '0)};
  endfunction

  // Stimulus for the next cycle
  logic         d_rst_n, d_v0, d_v1;
  logic [W-1:0] d_a0, d_b0, d_a1, d_b1;
  logic [2:0]   d_op0, d_op1;
  int           next_lat = 1;   // ALU latency of the next accepted op, 0 = never done
  bit           rand_lat = 1'b0;
  bit           spur_en  = 1'b0;

  // Reference model: one op in flight, described by its accept and response cycles
  bit            m_inflight = 1'b0;
  bit            m_last     = 1'b1;
  bit            m_gnt      = 1'b0;
  int            t_acc = 0, t_rsp = 0, m_lat = 1;
  logic [W-1:0]  m_a, m_b;
  logic [2:0]    m_op;
  logic [RW-1:0] e_res [2];
  logic [2:0]    e_flg [2];

  int             alu_cnt = -1;
  logic [RW+2:0]  alu_pend;

  task automatic run_cycle();
    bit            idle, win, e_start, in_wait, rsp_now;
    logic [RW+2:0] ref_v;
    @(posedge clk);
    #1;
    reset = d_rst_n;
    req0_valid = d_v0; req0_a = d_a0; req0_b = d_b0; req0_op = d_op0;
    req1_valid = d_v1; req1_a = d_a1; req1_b = d_b1; req1_op = d_op1;
    in_wait = m_inflight && cyc >= t_acc + 2 && cyc < t_rsp;
    alu_done = 1'b0;
    alu_result = RW'($urandom);
    {alu_ovf, alu_neg, alu_zero} = 3'($urandom);
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        alu_done = 1'b1;
        {alu_result, alu_ovf, alu_neg, alu_zero} = alu_pend;
        alu_cnt = -1;
      end
    end else if (spur_en && !in_wait && $urandom_range(0, 3) == 0) begin
      alu_done = 1'b1;
    end

    @(negedge clk);
    idle = !m_inflight;
    win  = (d_v0 && d_v1) ? !m_last : d_v1;
    check("req0_ready", 32'(req0_ready), 32'(idle && d_v0 && !win));
    check("req1_ready", 32'(req1_ready), 32'(idle && d_v1 && win));
    check("busy", 32'(busy), 32'(m_inflight));
    check("grant_id", 32'(grant_id), 32'(m_gnt));
    e_start = m_inflight && cyc == t_acc + 1;
    check("alu_start", 32'(alu_start), 32'(e_start));
    if (e_start) begin
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_op", 32'(alu_op), 32'(m_op));
    end
    if (alu_start === 1'b1 && m_lat != 0) begin
      alu_pend = alu_ref(alu_a, alu_b, alu_op);
      alu_cnt  = m_lat;
    end
    rsp_now = m_inflight && cyc == t_rsp;
    if (rsp_now) begin
      ref_v = (m_lat == 0) ? {RW'(0), 3'b100} : alu_ref(m_a, m_b, m_op);
      e_res[m_gnt] = ref_v[RW+2:3];
      e_flg[m_gnt] = ref_v[2:0];
    end
    check("req0_rsp_valid", 32'(req0_rsp_valid), 32'(rsp_now && !m_gnt));
    check("req1_rsp_valid", 32'(req1_rsp_valid), 32'(rsp_now && m_gnt));
    check("req0_result", 32'(req0_result), 32'(e_res[0]));
    check("req0_flags", 32'(req0_flags), 32'(e_flg[0]));
    check("req1_result", 32'(req1_result), 32'(e_res[1]));
    check("req1_flags", 32'(req1_flags), 32'(e_flg[1]));

    if (rsp_now) begin
      m_inflight = 1'b0;
      m_last     = m_gnt;
    end
    if (idle && (d_v0 || d_v1)) begin
      m_gnt      = win;
      m_a        = win ? d_a1 : d_a0;
      m_b        = win ? d_b1 : d_b0;
      m_op       = win ? d_op1 : d_op0;
      t_acc      = cyc;
      m_lat      = next_lat;
      t_rsp      = (m_lat == 0) ? cyc + TIMEOUT + 2 : cyc + m_lat + 2;
      m_inflight = 1'b1;
      if (rand_lat) next_lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
    end
    if (!d_rst_n) begin
      m_inflight = 1'b0;
      m_last     = 1'b1;
      m_gnt      = 1'b0;
      e_res[0] = '0; e_res[1] = '0;
      e_flg[0] = '0; e_flg[1] = '0;
    end
    cyc++;
  endtask

  task automatic set_req(input logic v0, input int a0, input int b0, input int op0,
                         input logic v1, input int a1, input int b1, input int op1);
    d_v0 = v0; d_a0 = W'(a0); d_b0 = W'(b0); d_op0 = 3'(op0);
    d_v1 = v1; d_a1 = W'(a1); d_b1 = W'(b1); d_op1 = 3'(op1);
  endtask

  task automatic idle_cycles(input int n);
    d_v0 = 1'b0;
    d_v1 = 1'b0;
    repeat (n) run_cycle();
  endtask

  initial begin
    e_res[0] = '0; e_res[1] = '0;
    e_flg[0] = '0; e_flg[1] = '0;
    reset = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    alu_done = 1'b0; alu_result = '0; alu_zero = 1'b0; alu_neg = 1'b0; alu_ovf = 1'b0;
    d_rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    run_cycle();
    d_rst_n = 1'b1;

    // Single request, 1-cycle ALU
    next_lat = 1;
    set_req(1, 3, 2, 0, 0, 0, 0, 0);
    run_cycle();
    idle_cycles(4);
    check("t1_result", 32'(req0_result), 32'd5);
    check("t1_flags", 32'(req0_flags), 32'd0);

    // Tie straight after reset goes to port 0, then port 1
    d_rst_n = 1'b0;
    idle_cycles(1);
    d_rst_n = 1'b1;
    set_req(1, 5, 3, 1, 1, 1, 4, 1);
    run_cycle();
    set_req(0, 7, 7, 2, 1, 1, 4, 1);
    repeat (6) run_cycle();
    idle_cycles(4);
    check("t2_req0_result", 32'(req0_result), 32'd2);
    check("t2_req1_result", 32'(req1_result), 32'b111101);
    check("t2_req1_flags", 32'(req1_flags), 32'b010);

    // Continuous requests from both ports
    repeat (24) begin
      set_req(1, $urandom, $urandom, $urandom, 1, $urandom, $urandom, $urandom);
      run_cycle();
    end
    idle_cycles(4);

    // Divide by zero on port 1
    set_req(0, 0, 0, 0, 1, 5, 0, 3);
    run_cycle();
    idle_cycles(4);
    check("t4_req1_result", 32'(req1_result), 32'd0);
    check("t4_req1_flags", 32'(req1_flags), 32'b101);

    // ALU never answers: watchdog response, then normal service resumes
    next_lat = 0;
    set_req(1, 2, 3, 0, 0, 0, 0, 0);
    run_cycle();
    next_lat = 1;
    idle_cycles(19);
    check("t5_result", 32'(req0_result), 32'd0);
    check("t5_flags", 32'(req0_flags), 32'b100);
    set_req(1, 1, 1, 0, 0, 0, 0, 0);
    run_cycle();
    idle_cycles(4);
    check("t5_next_result", 32'(req0_result), 32'd2);

    // Reset during WAIT; the late alu_done must be ignored
    next_lat = 4;
    set_req(0, 0, 0, 0, 1, 3, 3, 0);
    run_cycle();
    idle_cycles(2);
    d_rst_n = 1'b0;
    idle_cycles(1);
    d_rst_n = 1'b1;
    next_lat = 1;
    idle_cycles(5);
    set_req(1, 2, 2, 0, 1, 1, 1, 5);
    run_cycle();
    idle_cycles(4);
    check("t6_tie_result", 32'(req0_result), 32'd4);
    check("t6_req1_result", 32'(req1_result), 32'd0);

    // Randomized traffic with variable ALU latency and stray alu_done pulses
    spur_en  = 1'b1;
    rand_lat = 1'b1;
    next_lat = 2;
    repeat (500) begin
      set_req($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom,
              $urandom_range(0, 9) < 6, $urandom, $urandom, $urandom);
      run_cycle();
    end
    spur_en = 1'b0;
    idle_cycles(TIMEOUT + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
